// File: rtl/irq_pkg.sv
// Shared constants for the external interrupt controller: register word
// offsets, default source count and the architectural source limit.
package irq_pkg;

   localparam int N_SRC_DEFAULT = 8;
   localparam int MAX_SRC       = 31;
   localparam int BUS_DW        = 32;

   localparam logic [2:0] OFF_ENABLE  = 3'd0;
   localparam logic [2:0] OFF_MODE    = 3'd1;
   localparam logic [2:0] OFF_PENDING = 3'd2;
   localparam logic [2:0] OFF_CLAIM   = 3'd3;
   localparam logic [2:0] OFF_SOFT    = 3'd4;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchronizer bringing asynchronous interrupt lines into the clk domain.
module irq_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_d, meta_q;
   logic [W-1:0] sync_d, sync_q;

   always_comb begin
      meta_d = d_i;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronised edge/level sources, fixed-priority
// claim/complete arbitration and a software interrupt bit behind a simple bus.
module ext_irq_ctrl
   import irq_pkg::*;
#(
   parameter int N_SRC = N_SRC_DEFAULT,
   parameter int DW    = BUS_DW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] irq_src_i,
   input  logic             bus_req_i,
   input  logic             bus_we_i,
   input  logic [4:0]       bus_addr_i,
   input  logic [DW-1:0]    bus_wdata_i,
   output logic [DW-1:0]    bus_rdata_o,
   output logic             bus_ack_o,
   output logic             irq_ext_o,
   output logic             irq_soft_o
);

   logic [N_SRC-1:0] sync_lvl;
   logic [N_SRC-1:0] prev_d, prev_q;
   logic [1:0]       fill_d, fill_q;
   logic             armed;
   logic [N_SRC-1:0] rise;

   logic [N_SRC-1:0] enable_d, enable_q;
   logic [N_SRC-1:0] mode_d, mode_q;
   logic [N_SRC-1:0] pending_d, pending_q;
   logic [N_SRC-1:0] insvc_d, insvc_q;
   logic             soft_d, soft_q;
   logic             ack_d, ack_q;
   logic [DW-1:0]    rdata_d, rdata_q;

   logic [N_SRC-1:0] cand;
   logic             win_vld;
   logic [4:0]       win_id;

   logic [2:0]       word;
   logic             rd_req, wr_req, claim_rd;
   logic [N_SRC-1:0] claim_clr, done, w1c, mode_chg;
   logic             unused_addr;

   irq_sync #(.W(N_SRC)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (irq_src_i),
      .q_o   (sync_lvl)
   );

   // Edges are ignored until the chain and prev flop hold real post-reset samples,
   // so a line already high at reset release never looks like a rising edge.
   always_comb begin
      armed  = (fill_q == 2'd3);
      fill_d = armed ? fill_q : fill_q + 2'd1;
      prev_d = sync_lvl;
      rise   = armed ? (sync_lvl & ~prev_q) : '0;
   end

   // Fixed priority: lowest index wins among enabled, pending, not-in-service sources.
   always_comb begin
      cand    = pending_q & enable_q & ~insvc_q;
      win_vld = 1'b0;
      win_id  = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (cand[i]) begin
            win_vld = 1'b1;
            win_id  = 5'(i);
         end
      end
   end

   assign word        = bus_addr_i[4:2];
   assign rd_req      = bus_req_i & ~bus_we_i;
   assign wr_req      = bus_req_i & bus_we_i;
   assign claim_rd    = rd_req && (word == OFF_CLAIM) && win_vld;
   assign unused_addr = ^bus_addr_i[1:0];

   always_comb begin
      w1c = (wr_req && word == OFF_PENDING) ? bus_wdata_i[N_SRC-1:0] : '0;
      for (int i = 0; i < N_SRC; i++) begin
         claim_clr[i] = claim_rd && (win_id == 5'(i));
         done[i]      = wr_req && (word == OFF_CLAIM) && (bus_wdata_i == DW'(i + 1));
      end
   end

   always_comb begin
      enable_d = enable_q;
      mode_d   = mode_q;
      soft_d   = soft_q;
      if (wr_req && word == OFF_ENABLE) enable_d = bus_wdata_i[N_SRC-1:0];
      if (wr_req && word == OFF_MODE)   mode_d   = bus_wdata_i[N_SRC-1:0];
      if (wr_req && word == OFF_SOFT)   soft_d   = bus_wdata_i[0];
      mode_chg = mode_d ^ mode_q;

      insvc_d = (insvc_q | claim_clr) & ~done;

      // A new edge outranks a coincident claim/W1C; a mode switch outranks both.
      for (int i = 0; i < N_SRC; i++) begin
         if (mode_q[i]) pending_d[i] = (pending_q[i] & ~claim_clr[i] & ~w1c[i]) | rise[i];
         else           pending_d[i] = sync_lvl[i];
      end
      pending_d = pending_d & ~mode_chg;
   end

   always_comb begin
      ack_d   = bus_req_i;
      rdata_d = '0;
      if (rd_req) begin
         case (word)
            OFF_ENABLE:  rdata_d = DW'(enable_q);
            OFF_MODE:    rdata_d = DW'(mode_q);
            OFF_PENDING: rdata_d = DW'(pending_q);
            OFF_CLAIM:   rdata_d = win_vld ? DW'(win_id) + DW'(1) : '0;
            OFF_SOFT:    rdata_d = DW'(soft_q);
            default:     rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q    <= '0;
         fill_q    <= '0;
         enable_q  <= '0;
         mode_q    <= '0;
         pending_q <= '0;
         insvc_q   <= '0;
         soft_q    <= 1'b0;
         ack_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         prev_q    <= prev_d;
         fill_q    <= fill_d;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         pending_q <= pending_d;
         insvc_q   <= insvc_d;
         soft_q    <= soft_d;
         ack_q     <= ack_d;
         rdata_q   <= rdata_d;
      end
   end

   assign irq_ext_o   = |cand;
   assign irq_soft_o  = soft_q;
   assign bus_ack_o   = ack_q;
   assign bus_rdata_o = rdata_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl: a sample-history reference model checked every
// cycle, plus literal expectations for the key interrupt scenarios.
module tb_ext_irq_ctrl;

   localparam int N = 8;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  src   = '0;
   logic          req   = 1'b0;
   logic          we    = 1'b0;
   logic [4:0]    addr  = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          ack, irq_ext, irq_soft;

   ext_irq_ctrl #(.N_SRC(N), .DW(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .irq_src_i   (src),
      .bus_req_i   (req),
      .bus_we_i    (we),
      .bus_addr_i  (addr),
      .bus_wdata_i (wdata),
      .bus_rdata_o (rdata),
      .bus_ack_o   (ack),
      .irq_ext_o   (irq_ext),
      .irq_soft_o  (irq_soft)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: s1/s2/s3 are the source values sampled 1/2/3 edges ago.
   logic [N-1:0] m_en = '0, m_mode = '0, m_pend = '0, m_insvc = '0;
   logic [N-1:0] s1 = '0, s2 = '0, s3 = '0;
   logic         m_soft = 1'b0, m_ack = 1'b0;
   logic [31:0]  m_rdata = '0;
   int           m_edges = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en = '0; m_mode = '0; m_pend = '0; m_insvc = '0;
         s1 = '0; s2 = '0; s3 = '0;
         m_soft = 1'b0; m_ack = 1'b0; m_rdata = '0; m_edges = 0;
      end else begin : step
         logic [N-1:0] rise, live, pend_n, insvc_n, mode_n;
         logic [2:0]   wd;
         logic         rd, wr;
         int           winner, idx;
         if (m_edges < 100) m_edges++;
         rise   = (m_edges >= 4) ? (s2 & ~s3) : '0;
         live   = m_pend & m_en & ~m_insvc;
         winner = -1;
         for (int i = N - 1; i >= 0; i--) if (live[i]) winner = i;
         wd = addr[4:2];
         rd = req && !we;
         wr = req && we;
         m_ack   = req;
         m_rdata = 0;
         if (rd) begin
            case (wd)
               3'd0: m_rdata = 32'(m_en);
               3'd1: m_rdata = 32'(m_mode);
               3'd2: m_rdata = 32'(m_pend);
               3'd3: m_rdata = 32'(winner + 1);
               3'd4: m_rdata = 32'(m_soft);
               default: m_rdata = 0;
            endcase
         end
         insvc_n = m_insvc;
         if (rd && wd == 3'd3 && winner >= 0) insvc_n[winner] = 1'b1;
         if (wr && wd == 3'd3 && wdata >= 1 && wdata <= N) begin
            idx = int'(wdata) - 1;
            insvc_n[idx] = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
               pend_n[i] = m_pend[i];
               if (rd && wd == 3'd3 && winner == i) pend_n[i] = 1'b0;
               if (wr && wd == 3'd2 && wdata[i]) pend_n[i] = 1'b0;
               if (rise[i]) pend_n[i] = 1'b1;
            end else begin
               pend_n[i] = s2[i];
            end
         end
         mode_n = m_mode;
         if (wr && wd == 3'd1) mode_n = wdata[N-1:0];
         for (int i = 0; i < N; i++) if (mode_n[i] != m_mode[i]) pend_n[i] = 1'b0;
         if (wr && wd == 3'd0) m_en = wdata[N-1:0];
         if (wr && wd == 3'd4) m_soft = wdata[0];
         m_mode  = mode_n;
         m_pend  = pend_n;
         m_insvc = insvc_n;
         s3 = s2; s2 = s1; s1 = src;
      end
   end

   always @(negedge clk) begin
      check("ack", 32'(ack), 32'(m_ack));
      check("rdata", rdata, m_rdata);
      check("irq_ext", 32'(irq_ext), 32'(|(m_pend & m_en & ~m_insvc)));
      check("irq_soft", 32'(irq_soft), 32'(m_soft));
   end

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      req = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      req = 1'b0; we = 1'b0; wdata = '0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      req = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      d = rdata;
      req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;
      @(negedge clk);
      idle(2);
      check("rst_ack", 32'(ack), 0);
      check("rst_rdata", rdata, 0);
      check("rst_irq_ext", 32'(irq_ext), 0);
      check("rst_irq_soft", 32'(irq_soft), 0);
      rst_n = 1'b1;
      idle(5);

      // single edge source, latency, claim and complete
      wr(5'd4, 32'h05);
      wr(5'd0, 32'h05);
      src = 8'h04;
      idle(2);
      check("A_latency_k1", 32'(irq_ext), 0);
      src = 8'h00;
      idle(1);
      check("A_irq_set", 32'(irq_ext), 1);
      rd(5'd8, d);  check("A_pending", d, 32'h04);
      rd(5'd12, d); check("A_claim", d, 3);
      check("A_irq_after_claim", 32'(irq_ext), 0);
      wr(5'd12, 32'd3);
      rd(5'd8, d);  check("A_pending_clr", d, 0);

      // simultaneous edges, priority order
      src = 8'h05;
      idle(1);
      src = 8'h00;
      idle(4);
      rd(5'd12, d); check("B_claim1", d, 1);
      check("B_irq_still", 32'(irq_ext), 1);
      rd(5'd12, d); check("B_claim2", d, 3);
      check("B_irq_drop", 32'(irq_ext), 0);
      wr(5'd12, 32'd1);
      wr(5'd12, 32'd3);

      // level mode source held through claim/complete
      wr(5'd4, 32'h00);
      wr(5'd0, 32'h02);
      src = 8'h02;
      idle(4);
      check("C_irq", 32'(irq_ext), 1);
      rd(5'd12, d); check("C_claim", d, 2);
      check("C_irq_insvc", 32'(irq_ext), 0);
      wr(5'd12, 32'd2);
      check("C_irq_reassert", 32'(irq_ext), 1);
      src = 8'h00;
      idle(4);
      rd(5'd8, d);  check("C_pending_low", d, 0);

      // new edge landing on the claim edge
      wr(5'd4, 32'h05);
      wr(5'd0, 32'h05);
      src = 8'h04;
      idle(1);
      src = 8'h00;
      idle(5);
      check("D_irq", 32'(irq_ext), 1);
      src = 8'h04;
      idle(2);
      rd(5'd12, d); check("D_claim", d, 3);
      rd(5'd8, d);  check("D_pending_kept", d, 32'h04);
      wr(5'd12, 32'd3);
      check("D_irq_again", 32'(irq_ext), 1);
      rd(5'd12, d); check("D_claim2", d, 3);
      wr(5'd12, 32'd3);
      src = 8'h00;
      idle(2);

      // soft interrupt, unmapped offset, bits above N_SRC
      wr(5'd16, 32'h1);
      check("E_soft", 32'(irq_soft), 1);
      rd(5'd24, d); check("E_off6", d, 0);
      wr(5'd24, 32'hFFFF_FFFF);
      wr(5'd0, 32'hFFFF_FFFF);
      rd(5'd0, d);  check("E_enable_mask", d, 32'hFF);
      rd(5'd8, d);  check("E_pending_bit8", 32'(d[8]), 0);
      wr(5'd0, 32'h0);

      // reset while a claim read is being acknowledged
      wr(5'd4, 32'h04);
      wr(5'd0, 32'h04);
      src = 8'h04;
      idle(1);
      src = 8'h00;
      idle(4);
      check("F_irq", 32'(irq_ext), 1);
      req = 1'b1; we = 1'b0; addr = 5'd12;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("F_ack", 32'(ack), 0);
      check("F_rdata", rdata, 0);
      check("F_irq_ext", 32'(irq_ext), 0);
      check("F_irq_soft", 32'(irq_soft), 0);
      @(negedge clk);
      req = 1'b0;
      src = 8'h04;
      idle(2);
      rst_n = 1'b1;

      // source already high at reset release
      wr(5'd4, 32'h04);
      wr(5'd0, 32'h04);
      idle(8);
      check("G_no_edge", 32'(irq_ext), 0);
      rd(5'd8, d);  check("G_pending", d, 0);
      src = 8'h00;
      idle(3);
      src = 8'h04;
      idle(3);
      check("G_real_edge", 32'(irq_ext), 1);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
